reg_write_scoreboard: RTL and testbench
=======================================

Name: reg_write_scoreboard

Overview:
- Read-side counterpart of the writeback-enable decode: tracks registers with a writeback still in flight and stalls decode while a source operand is not yet written.
- Sits between decode and the register file. Decode reports each issued instruction's destination and regWrite flag; writeback reports each completed write.
- Produces the decode stall and a per-register pending vector. Replaces ad-hoc hazard compares.

Parameters:
- NREG, 8, number of architectural registers.
- IDXW, 3, register index width; NREG = 2**IDXW.
- CNTW, 3, per-register in-flight counter width; maximum in-flight writes per register is 2**CNTW-1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all pending state (branch mispredict or exception)
- iss_valid  input  1  decode presents an instruction this cycle
- iss_regwrite  input  1  instruction writes a register (from opcode decode)
- iss_rd  input  IDXW  destination register index
- src1_valid  input  1  instruction reads src1
- src1_idx  input  IDXW  source 1 index
- src2_valid  input  1  instruction reads src2
- src2_idx  input  IDXW  source 2 index
- wb_valid  input  1  writeback commits a register write this cycle
- wb_rd  input  IDXW  writeback destination index
- stall  output  1  decode must hold the instruction; combinational
- iss_accept  output  1  iss_valid & ~stall; combinational
- pending  output  NREG  bit i = cnt[i] != 0; registered state
- err  output  1  sticky error flag: overflow or underflow seen

Behaviour:
- State: cnt[i], CNTW bits per register; err_q sticky.
- Reset (rst_n=0, async): all cnt=0, err=0. pending=0, stall=0 while in reset.
- Stall conditions: stall = iss_valid & (hazard1 | hazard2 | full_rd).
  - hazard1 = src1_valid & pending[src1_idx]; hazard2 likewise for src2.
  - full_rd = iss_regwrite & (cnt[iss_rd] == max).
  - Same-cycle writeback does NOT bypass: a register pending with cnt=1 and wb_valid for it still stalls this cycle. The stall clears next cycle; latency is 1 cycle after wb.
- Register 0 is tracked like any other register. There is no hardwired-zero special case.
- Per-cycle update for each register i:
  - inc = iss_accept & iss_regwrite & (iss_rd==i)
  - dec = wb_valid & (wb_rd==i)
  - inc & ~dec: cnt+1
  - dec & ~inc: cnt-1
  - both or neither: hold
- Underflow: dec with cnt=0 and no inc leaves cnt at 0 and sets err.
- Overflow cannot occur through the accepted path because full_rd stalls.
- flush=1: next state of all cnt is 0 regardless of iss/wb that cycle. err is held. Accepts during a flush cycle are discarded.
- err is sticky until rst_n.
- iss_accept is never asserted while rst_n=0.
- No state machine beyond the counters. The block is purely counter-based scoreboarding.

Decomposition:
- Shared package: IDXW, NREG, CNTW defaults and the pending-counter max constant.
- One natural sub-module: sb_counter, one instance per register. It has inc, dec and clr inputs, cnt and nz outputs, and an underflow pulse. Generate NREG instances; the top level does index decode and stall logic.

Test Plan:
- Reset, then issue r3 (regwrite=1, no sources) -> iss_accept=1; next cycle pending=8'b0000_1000.
- r3 pending, issue with src1=r3 -> stall=1 and iss_accept=0. Assert wb_valid wb_rd=3 -> stall still 1 that cycle; stall=0 the following cycle, pending=0.
- Issue r5 with regwrite in the same cycle as wb r5, starting from cnt[5]=1 -> cnt[5] stays 1 and pending[5]=1. Then wb r5 -> pending[5]=0.
- Issue r2 seven times with no wb -> cnt[2]=7. The 8th issue to r2 -> stall=1 (full_rd). One wb r2 -> the 8th issue is accepted the next cycle.
- wb_valid wb_rd=6 with cnt[6]=0 -> err=1 and stays 1. cnt[6] stays 0. After a flush, err is still 1.
- Pending r1 and r4, assert flush together with an accepted issue to r7 -> next cycle pending=0. Assert rst_n=0 mid-run -> pending=0 and err=0 immediately (asynchronous).

Source files
------------

// File: rtl/reg_write_scoreboard_pkg.sv
// Shared sizing and constants for the register write scoreboard.
package reg_write_scoreboard_pkg;
    localparam int IDXW = 3;
    localparam int NREG = 2 ** IDXW;
    localparam int CNTW = 3;

    // Largest number of writes that may be in flight to one register.
    localparam logic [CNTW-1:0] CNT_MAX = '1;
endpackage

// File: rtl/reg_write_scoreboard_sb_counter.sv
// One in-flight write counter for a single architectural register.
module reg_write_scoreboard_sb_counter
    import reg_write_scoreboard_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc_i,
    input  logic            dec_i,
    input  logic            clr_i,
    output logic [CNTW-1:0] cnt_o,
    output logic            nz_o,
    output logic            underflow_o
);

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    // Next count: clear wins, simultaneous inc/dec cancel, a decrement at zero saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign nz_o        = (cnt_q != '0);
    // A writeback for a register with nothing in flight; suppressed while clearing.
    assign underflow_o = dec_i && !inc_i && !clr_i && (cnt_q == '0);

endmodule

// File: rtl/reg_write_scoreboard.sv
// Scoreboard of registers with writebacks in flight; stalls decode on a RAW hazard
// or when the destination counter is saturated.
module reg_write_scoreboard
    import reg_write_scoreboard_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            iss_valid,
    input  logic            iss_regwrite,
    input  logic [IDXW-1:0] iss_rd,
    input  logic            src1_valid,
    input  logic [IDXW-1:0] src1_idx,
    input  logic            src2_valid,
    input  logic [IDXW-1:0] src2_idx,
    input  logic            wb_valid,
    input  logic [IDXW-1:0] wb_rd,
    output logic            stall,
    output logic            iss_accept,
    output logic [NREG-1:0] pending,
    output logic            err
);

    logic [CNTW-1:0] cnt [NREG];
    logic [NREG-1:0] nz;
    logic [NREG-1:0] inc;
    logic [NREG-1:0] dec;
    logic [NREG-1:0] uflow;
    logic            hazard1;
    logic            hazard2;
    logic            full_rd;
    logic            err_q;
    logic            err_d;

    // Hazard and saturation checks use registered state only: a same-cycle
    // writeback does not release the stall until the following cycle.
    always_comb begin
        hazard1    = src1_valid && nz[src1_idx];
        hazard2    = src2_valid && nz[src2_idx];
        full_rd    = iss_regwrite && (cnt[iss_rd] == CNT_MAX);
        stall      = iss_valid && (hazard1 || hazard2 || full_rd);
        iss_accept = iss_valid && !stall && rst_n;
    end

    // Per-register increment/decrement decode.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            inc[i] = iss_accept && iss_regwrite && (iss_rd == IDXW'(i));
            dec[i] = wb_valid && (wb_rd == IDXW'(i));
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_cnt
        reg_write_scoreboard_sb_counter u_cnt (
            .clk         (clk),
            .rst_n       (rst_n),
            .inc_i       (inc[g]),
            .dec_i       (dec[g]),
            .clr_i       (flush),
            .cnt_o       (cnt[g]),
            .nz_o        (nz[g]),
            .underflow_o (uflow[g])
        );
    end

    assign err_d = err_q || (|uflow);

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign pending = nz;
    assign err     = err_q;

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Self-checking bench for reg_write_scoreboard: directed scenarios plus random traffic
// against a per-register in-flight count model.
module tb_reg_write_scoreboard;
    import reg_write_scoreboard_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            iss_valid;
    logic            iss_regwrite;
    logic [IDXW-1:0] iss_rd;
    logic            src1_valid;
    logic [IDXW-1:0] src1_idx;
    logic            src2_valid;
    logic [IDXW-1:0] src2_idx;
    logic            wb_valid;
    logic [IDXW-1:0] wb_rd;
    logic            stall;
    logic            iss_accept;
    logic [NREG-1:0] pending;
    logic            err;

    int n_cmp = 0;
    int n_mis = 0;

    int m_cnt [NREG];
    bit m_err;

    localparam int MAX_INFLIGHT = 2 ** CNTW - 1;

    reg_write_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .iss_valid    (iss_valid),
        .iss_regwrite (iss_regwrite),
        .iss_rd       (iss_rd),
        .src1_valid   (src1_valid),
        .src1_idx     (src1_idx),
        .src2_valid   (src2_valid),
        .src2_idx     (src2_idx),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .stall        (stall),
        .iss_accept   (iss_accept),
        .pending      (pending),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit iv, input bit rw, input int rd,
                         input bit s1v, input int s1, input bit s2v, input int s2,
                         input bit wv, input int wr, input bit fl);
        iss_valid    = iv;
        iss_regwrite = rw;
        iss_rd       = rd[IDXW-1:0];
        src1_valid   = s1v;
        src1_idx     = s1[IDXW-1:0];
        src2_valid   = s2v;
        src2_idx     = s2[IDXW-1:0];
        wb_valid     = wv;
        wb_rd        = wr[IDXW-1:0];
        flush        = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
        m_err = 1'b0;
    endtask

    function automatic logic [NREG-1:0] model_pending();
        logic [NREG-1:0] p;
        for (int i = 0; i < NREG; i++) p[i] = (m_cnt[i] != 0);
        return p;
    endfunction

    function automatic bit model_stall();
        bit h1, h2, full;
        h1   = src1_valid && (m_cnt[src1_idx] != 0);
        h2   = src2_valid && (m_cnt[src2_idx] != 0);
        full = iss_regwrite && (m_cnt[iss_rd] == MAX_INFLIGHT);
        return iss_valid && (h1 || h2 || full);
    endfunction

    // Inputs are already driven (just after a falling edge). Check outputs against
    // the model, take one rising edge, advance the model, return at the next falling edge.
    task automatic step(input string tag);
        bit es, ea;
        #1;
        if (!rst_n) model_reset();
        es = model_stall();
        ea = rst_n && iss_valid && !es;
        chk({tag, "_stall"},   32'(stall),      32'(es));
        chk({tag, "_accept"},  32'(iss_accept), 32'(ea));
        chk({tag, "_pending"}, 32'(pending),    32'(model_pending()));
        chk({tag, "_err"},     32'(err),        32'(m_err));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (flush) begin
            for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                bit inc, dec;
                inc = ea && iss_regwrite && (iss_rd == IDXW'(i));
                dec = wb_valid && (wb_rd == IDXW'(i));
                if (inc && !dec) begin
                    m_cnt[i]++;
                end else if (dec && !inc) begin
                    if (m_cnt[i] == 0) m_err = 1'b1;
                    else m_cnt[i]--;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        step("rst0");
        chk("rst_pending_const", 32'(pending), 32'h0);
        step("rst1");
        rst_n = 1'b1;

        // Issue r3 with no sources: accepted, r3 pending next cycle.
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("t1_accept_const", 32'(iss_accept), 32'h1);
        step("t1_iss");
        idle();
        chk("t1_pending_const", 32'(pending), 32'h08);

        // RAW on r3; writeback in the same cycle does not bypass.
        drive(1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        #1 chk("t2_stall_const", 32'(stall), 32'h1);
        step("t2_raw");
        drive(1, 0, 0, 1, 3, 0, 0, 1, 3, 0);
        #1 chk("t2_stall_wb_const", 32'(stall), 32'h1);
        step("t2_wb");
        drive(1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        #1 chk("t2_release_const", 32'(stall), 32'h0);
        chk("t2_pending_const", 32'(pending), 32'h0);
        step("t2_go");

        // Issue and writeback to r5 in the same cycle hold the count.
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        step("t3_iss");
        drive(1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
        step("t3_both");
        idle();
        chk("t3_hold_const", 32'(pending[5]), 32'h1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
        step("t3_wb");
        idle();
        chk("t3_clear_const", 32'(pending[5]), 32'h0);

        // Saturate r2 with seven writes, eighth stalls until one retires.
        for (int k = 0; k < MAX_INFLIGHT; k++) begin
            drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
            step("t4_fill");
        end
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("t4_full_const", 32'(stall), 32'h1);
        step("t4_full");
        drive(1, 1, 2, 0, 0, 0, 0, 1, 2, 0);
        step("t4_full_wb");
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("t4_accept_const", 32'(iss_accept), 32'h1);
        step("t4_accept");

        // Underflow on r6 sets a sticky error that survives a flush.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("t5_flush0");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
        step("t5_uflow");
        idle();
        chk("t5_err_const", 32'(err), 32'h1);
        chk("t5_cnt6_const", 32'(pending[6]), 32'h0);
        step("t5_idle");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("t5_flush1");
        idle();
        chk("t5_err_sticky_const", 32'(err), 32'h1);

        // Flush wins over an accepted issue in the same cycle.
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step("t6_r1");
        drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        step("t6_r4");
        drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 1);
        step("t6_flush");
        idle();
        chk("t6_pending_const", 32'(pending), 32'h0);

        // Asynchronous reset takes effect before any clock edge.
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step("t7_r1");
        rst_n = 1'b0;
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t7_arst_pending", 32'(pending), 32'h0);
        chk("t7_arst_err", 32'(err), 32'h0);
        chk("t7_arst_accept", 32'(iss_accept), 32'h0);
        model_reset();
        step("t7_arst");
        rst_n = 1'b1;

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            int q[$];
            bit fl, wv;
            int wr;
            fl = ($urandom_range(0, 29) == 0);
            wv = !fl && ($urandom_range(0, 1) == 1);
            for (int i = 0; i < NREG; i++) if (m_cnt[i] != 0) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 19) != 0)
                wr = q[$urandom_range(0, q.size() - 1)];
            else
                wr = $urandom_range(0, NREG - 1);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, NREG - 1),
                  $urandom_range(0, 1), $urandom_range(0, NREG - 1),
                  $urandom_range(0, 1), $urandom_range(0, NREG - 1),
                  wv, wr, fl);
            step("rnd");
        end

        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
